// File: rtl/count_seq_pkg.sv
// Shared definitions for the count sequencing controller and its counter core.
package count_seq_pkg;

  // Default counter / terminal-count width.
  localparam int DEFAULT_WIDTH = 4;

  // Controller state encoding. The spare code 2'b11 is never entered
  // on purpose; if it ever shows up it recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_BAD   = 2'b11
  } state_t;

  // A timer is busy while it is running or paused.
  function automatic logic is_busy(input state_t s);
    return (s == ST_RUN) || (s == ST_PAUSE);
  endfunction

endpackage

// File: rtl/count_core.sv
// WIDTH-bit up-counter with synchronous clear (dominant) and enable,
// asynchronous active-low reset.
module count_core
  import count_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  // Count register: clear wins over enable.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/count_seq_ctrl.sv
// Sequencing controller: turns the counter core into a one-shot or
// periodic timer with pause (Hold) and abort (Stop). Owns the counter's
// enable and clear, and emits a registered one-cycle Done pulse at each
// terminal count.
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Hold,
  input  logic             Periodic,
  input  logic [WIDTH-1:0] Tc,
  output logic [WIDTH-1:0] Q,
  output logic             Cnt_en,
  output logic             Busy,
  output logic             Done,
  output state_t           dbg_state
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] tc_r;
  logic             per_r;
  logic             done_q;
  logic             terminal;
  logic             run_go;
  logic             load;
  logic             done_d;
  logic             core_clr;

  // Terminal compare against the value latched at Start, so Q never
  // runs past tc_r and later changes to Tc have no effect.
  assign terminal = (Q == tc_r);

  // An un-held, un-aborted RUN cycle either counts or hits terminal.
  assign run_go   = (state_q == ST_RUN) && !Hold && !Stop;
  assign done_d   = run_go && terminal;
  assign load     = (state_q == ST_IDLE) && Start && !Stop;

  // Clear the count on abort, on terminal, and whenever the timer is
  // not busy so IDLE (and the spare code) always shows Q=0.
  assign core_clr = Stop || done_d || !is_busy(state_q);

  assign Cnt_en    = run_go;
  assign Busy      = is_busy(state_q);
  assign Done      = done_q;
  assign dbg_state = state_q;

  // Next-state logic; Stop dominates everything, Start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    if (Stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (Hold) begin
            state_d = ST_PAUSE;
          end else if (terminal && !per_r) begin
            state_d = ST_IDLE;
          end
        end
        ST_PAUSE: begin
          if (!Hold) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Terminal count and mode are captured only when arming from IDLE.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tc_r  <= '0;
      per_r <= 1'b0;
    end else if (load) begin
      tc_r  <= Tc;
      per_r <= Periodic;
    end
  end

  // Done is high for exactly the cycle after a terminal edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  count_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .clr   (core_clr),
    .en    (Cnt_en),
    .q     (Q)
  );

endmodule
